// File: rtl/weight_pkg.sv
// Shared types and constants for the weight RAM read path: geometry, FSM states,
// stream tag layout and the autoencoder layer table.
package weight_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 33;
   localparam int DIM_W  = 10;
   localparam int DEPTH  = 790388;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BIAS   = 2'd1,
      ST_WEIGHT = 2'd2,
      ST_DRAIN  = 2'd3
   } wsr_state_t;

   typedef struct packed {
      logic             bias;
      logic [DIM_W-1:0] row;
      logic [DIM_W-1:0] col;
      logic             last_row;
      logic             last_layer;
   } wsr_tag_t;

   localparam int TAG_W = $bits(wsr_tag_t);

   // Words in one layer block (biases plus weights), one bit wider than an index.
   function automatic logic [ADDR_W:0] layer_words(input int unsigned din, input int unsigned dout);
      return (ADDR_W+1)'(dout) * ((ADDR_W+1)'(din) + (ADDR_W+1)'(1));
   endfunction

   // Autoencoder layer table, blocks packed back to back from index 0.
   localparam logic [DIM_W-1:0] L0_D_IN  = DIM_W'(784);
   localparam logic [DIM_W-1:0] L0_D_OUT = DIM_W'(400);
   localparam logic [DIM_W-1:0] L1_D_IN  = DIM_W'(400);
   localparam logic [DIM_W-1:0] L1_D_OUT = DIM_W'(200);
   localparam logic [DIM_W-1:0] L2_D_IN  = DIM_W'(200);
   localparam logic [DIM_W-1:0] L2_D_OUT = DIM_W'(400);
   localparam logic [DIM_W-1:0] L3_D_IN  = DIM_W'(400);
   localparam logic [DIM_W-1:0] L3_D_OUT = DIM_W'(784);

   localparam logic [ADDR_W-1:0] L0_BASE = '0;
   localparam logic [ADDR_W-1:0] L1_BASE = L0_BASE + ADDR_W'(layer_words(784, 400));
   localparam logic [ADDR_W-1:0] L2_BASE = L1_BASE + ADDR_W'(layer_words(400, 200));
   localparam logic [ADDR_W-1:0] L3_BASE = L2_BASE + ADDR_W'(layer_words(200, 400));

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO carrying {tag, data} from the RAM read port to the output stream.
// The head entry only moves on pop, so the output is stable while stalled.
module skid_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/weight_stream_reader.sv
// Reads one layer block (biases, then row-major weights) from the weight RAM and
// streams it with tags under full backpressure. Define WSR_CHECKSUM_EN for the checksum port.
//
// state     | meaning
// ST_IDLE   | waiting for start; validates the request
// ST_BIAS   | issuing d_out bias reads
// ST_WEIGHT | issuing d_in*d_out weight reads
// ST_DRAIN  | all reads issued; waiting for the FIFO and in-flight read to empty
module weight_stream_reader
   import weight_pkg::*;
#(
   parameter int DATA_W = weight_pkg::DATA_W,
   parameter int ADDR_W = weight_pkg::ADDR_W,
   parameter int DIM_W  = weight_pkg::DIM_W,
   parameter int DEPTH  = weight_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [DIM_W-1:0]  d_in,
   input  logic [DIM_W-1:0]  d_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] ram_index,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_bias,
   output logic [DIM_W-1:0]  out_row,
   output logic [DIM_W-1:0]  out_col,
   output logic              out_last_row,
   output logic              out_last_layer
`ifdef WSR_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   wsr_state_t        state;
   wsr_state_t        state_next;
   logic [DIM_W-1:0]  d_in_q;
   logic [DIM_W-1:0]  d_out_q;
   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  col_q;
   logic [ADDR_W-1:0] idx_q;
   logic              inflight_q;
   wsr_tag_t          tag_q;
   wsr_tag_t          issue_tag;
   wsr_tag_t          head_tag;
   logic              done_q;
   logic              err_q;

   logic [ADDR_W:0]   n_words;
   logic [ADDR_W:0]   end_idx;
   logic              req_ok;
   logic              accept;
   logic              reject;
   logic              drain_done;
   logic              issue;
   logic              row_last;
   logic              col_last;
   logic              final_issue;
   logic [1:0]        occ;
   logic [1:0]        occ_after;
   logic              pop;
   logic [2:0]        level;
   logic [TAG_W+DATA_W-1:0] fifo_head;

   assign n_words = layer_words(int'(d_in), int'(d_out));
   assign end_idx = {1'b0, base} + n_words;
   assign req_ok  = (d_in != '0) && (d_out != '0) && (end_idx <= DEPTH_X);

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && out_ready;
   assign occ_after = occ - {1'b0, pop};

   // Occupancy after this cycle's pop plus the read still in flight must leave a free slot.
   assign level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = ((state == ST_BIAS) || (state == ST_WEIGHT)) && (level < 3'd2);

   assign row_last    = (row_q == d_out_q - DIM_W'(1));
   assign col_last    = (col_q == d_in_q - DIM_W'(1));
   assign final_issue = (state == ST_WEIGHT) && col_last && row_last;

   always_comb begin
      issue_tag            = '0;
      issue_tag.bias       = (state == ST_BIAS);
      issue_tag.row        = row_q;
      issue_tag.col        = (state == ST_BIAS) ? '0 : col_q;
      issue_tag.last_row   = (state == ST_BIAS) ? row_last : col_last;
      issue_tag.last_layer = final_issue;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      reject     = 1'b0;
      drain_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (req_ok) begin
                  accept     = 1'b1;
                  state_next = ST_BIAS;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_BIAS: begin
            if (issue && row_last)
               state_next = ST_WEIGHT;
         end
         ST_WEIGHT: begin
            if (issue && final_issue)
               state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!inflight_q && (occ_after == 2'd0)) begin
               drain_done = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= reject || drain_done;
         if (reject)
            err_q <= 1'b1;
         else if (accept)
            err_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_in_q     <= '0;
         d_out_q    <= '0;
         row_q      <= '0;
         col_q      <= '0;
         idx_q      <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         inflight_q <= issue;
         if (issue)
            tag_q <= issue_tag;
         if (accept) begin
            d_in_q  <= d_in;
            d_out_q <= d_out;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= base;
         end else if (issue) begin
            // Index stays on the last word so it never walks past the block.
            if (!final_issue)
               idx_q <= idx_q + ADDR_W'(1);
            if (state == ST_BIAS) begin
               row_q <= row_last ? '0 : row_q + DIM_W'(1);
            end else if (col_last) begin
               col_q <= '0;
               if (!row_last)
                  row_q <= row_q + DIM_W'(1);
            end else begin
               col_q <= col_q + DIM_W'(1);
            end
         end
      end
   end

   skid_fifo2 #(.W(TAG_W + DATA_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data ({tag_q, ram_data}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (occ)
   );

   assign head_tag       = fifo_head[DATA_W +: TAG_W];
   assign out_data       = fifo_head[DATA_W-1:0];
   assign out_bias       = head_tag.bias;
   assign out_row        = head_tag.row;
   assign out_col        = head_tag.col;
   assign out_last_row   = head_tag.last_row;
   assign out_last_layer = head_tag.last_layer;

   assign busy      = (state != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign ram_index = idx_q;
   assign ram_write = 1'b0;

`ifdef WSR_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         checksum <= '0;
      else if (accept)
         checksum <= '0;
      else if (pop)
         checksum <= checksum + {{(32-DATA_W){1'b0}}, out_data};
   end
`endif

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader: a scoreboard of expected tagged words is
// filled at each start and drained by a monitor on every stream transfer.
module tb_weight_stream_reader;
   import weight_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [DIM_W-1:0]  d_in;
   logic [DIM_W-1:0]  d_out;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] ram_index;
   logic              ram_write;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_bias;
   logic [DIM_W-1:0]  out_row;
   logic [DIM_W-1:0]  out_col;
   logic              out_last_row;
   logic              out_last_layer;
`ifdef WSR_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              bias;
      logic [DIM_W-1:0]  row;
      logic [DIM_W-1:0]  col;
      logic              lr;
      logic              ll;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          xfer_cnt = 0;
   logic [31:0] sum_model = '0;

   weight_stream_reader dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base           (base),
      .d_in           (d_in),
      .d_out          (d_out),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .ram_index      (ram_index),
      .ram_write      (ram_write),
      .ram_data       (ram_data),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_bias       (out_bias),
      .out_row        (out_row),
      .out_col        (out_col),
      .out_last_row   (out_last_row),
      .out_last_layer (out_last_layer)
`ifdef WSR_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM holding RAM[i] = i + 100.
   always @(posedge clk) ram_data <= DATA_W'(ram_index + ADDR_W'(100));

   function automatic exp_t mk(input logic [DATA_W-1:0] d, input logic b,
                               input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c,
                               input logic lr, input logic ll);
      exp_t e;
      e.data = d; e.bias = b; e.row = r; e.col = c; e.lr = lr; e.ll = ll;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_layer(input logic [ADDR_W-1:0] b, input int di, input int dn);
      logic [ADDR_W-1:0] idx;
      for (int r = 0; r < dn; r++) begin
         idx = b + ADDR_W'(r);
         sb.push_back(mk(DATA_W'(idx + ADDR_W'(100)), 1'b1, DIM_W'(r), '0, r == dn-1, 1'b0));
      end
      for (int r = 0; r < dn; r++)
         for (int c = 0; c < di; c++) begin
            idx = b + ADDR_W'(dn + r*di + c);
            sb.push_back(mk(DATA_W'(idx + ADDR_W'(100)), 1'b0, DIM_W'(r), DIM_W'(c),
                            c == di-1, (c == di-1) && (r == dn-1)));
         end
   endtask

   // Scoreboard monitor: compares every transfer and checks hold-stability under stall.
   exp_t obs_w, held, e;
   logic stalled = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         obs_w = mk(out_data, out_bias, out_row, out_col, out_last_row, out_last_layer);
         if (stalled) begin
            checks++;
            assert (out_valid === 1'b1 && obs_w === held) else begin
               errors++;
               $error("FAIL stall_hold observed=%h/%b expected=%h/1", obs_w, out_valid, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL stream_extra observed=%h expected=none", obs_w);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               assert (obs_w === e) else begin
                  errors++;
                  $error("FAIL stream_word observed=%h expected=%h", obs_w, e);
               end
               sum_model = sum_model + {16'b0, e.data};
            end
            xfer_cnt++;
         end
         stalled = out_valid && !out_ready;
         held    = obs_w;
      end
   end

   // Runs one accepted layer; mode 1 applies the ready pattern 1,0,0,1 and a start while busy.
   task automatic run_layer(input logic [ADDR_W-1:0] b, input int di, input int dn, input int mode,
                            output int t_first, output int t_last, output int t_done);
      logic [3:0] pat;
      int c;
      pat = (mode == 1) ? 4'b1001 : 4'b1111;
      t_first = -1; t_last = -1; t_done = -1;
      push_layer(b, di, dn);
      @(posedge clk); #1;
      start = 1'b1; base = b; d_in = DIM_W'(di); d_out = DIM_W'(dn); out_ready = pat[0];
      @(posedge clk); #1;
      start = 1'b0;
      sum_model = '0;
      check("busy_after_start", busy, 1);
      check("index_is_base", ram_index, b);
      c = 0;
      while (c < 300) begin
         @(negedge clk);
         if (out_valid && t_first < 0) t_first = c;
         if (out_valid && out_ready) t_last = c;
         if (done) begin
            t_done = c;
            break;
         end
         @(posedge clk); #1;
         c++;
         out_ready = pat[c % 4];
         if (mode == 1 && c == 3) begin start = 1'b1; base = ADDR_W'(500); end
         if (mode == 1 && c == 4) begin start = 1'b0; base = b; end
      end
      check("done_seen", t_done >= 0, 1);
      check("sb_empty_at_done", sb.size(), 0);
      check("busy_low_at_done", busy, 0);
      check("err_clear_at_done", err, 0);
      check("done_after_last_xfer", t_done, t_last + 1);
`ifdef WSR_CHECKSUM_EN
      check("checksum", checksum, sum_model);
`endif
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      out_ready = 1'b1;
   endtask

   task automatic run_reject(input logic [ADDR_W-1:0] b, input int di, input int dn, input string tag);
      logic [ADDR_W-1:0] idx0;
      idx0 = ram_index;
      @(posedge clk); #1;
      start = 1'b1; base = b; d_in = DIM_W'(di); d_out = DIM_W'(dn);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_done"}, done, 1);
      check({tag, "_err"}, err, 1);
      check({tag, "_busy"}, busy, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check({tag, "_noread"}, {out_valid, busy, ram_index}, {2'b00, idx0});
      end
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_err_held"}, err, 1);
   endtask

   int tf, tl, td, x0, c;

   initial begin
      rst = 1'b1; start = 1'b0; base = '0; d_in = '0; d_out = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", {busy, done, err, out_valid, ram_index}, '0);
      check("rst_tags", {out_bias, out_row, out_col, out_last_row, out_last_layer}, '0);
      check("ram_write", ram_write, 0);
`ifdef WSR_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
      rst = 1'b0;

      // Full-rate layer: first word two cycles after acceptance, done N+2 cycles after.
      run_layer('0, 3, 2, 0, tf, tl, td);
      check("lat_first_valid", tf, 2);
      check("lat_last_xfer", tl, 9);
      check("lat_done", td, 10);

      // Same layer under stalls, with a start while busy that must be ignored.
      run_layer('0, 3, 2, 1, tf, tl, td);

      run_reject(ADDR_W'(0), 0, 2, "rej_din0");
      run_reject(ADDR_W'(0), 3, 0, "rej_dout0");
      run_reject(ADDR_W'(790381), 3, 2, "rej_bounds");

      // Exactly fits the last words of the RAM; also clears the held err.
      run_layer(ADDR_W'(790380), 3, 2, 0, tf, tl, td);
      check("edge_lat_done", td, 10);

      // Reset after three transfers: immediate idle, no done, scoreboard discarded.
      push_layer('0, 3, 2);
      @(posedge clk); #1;
      start = 1'b1; base = '0; d_in = DIM_W'(3); d_out = DIM_W'(2);
      @(posedge clk); #1;
      start = 1'b0;
      x0 = xfer_cnt;
      for (c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (xfer_cnt >= x0 + 3) break;
      end
      check("rst_reach_3_xfers", c < 40, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_busy_valid_done", {busy, out_valid, done}, 3'b000);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rst_no_done", {done, busy, out_valid}, 3'b000);
      end

      run_layer('0, 3, 2, 0, tf, tl, td);
      check("replay_lat_first", tf, 2);
      check("replay_lat_done", td, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
